// File: rtl/mul_sched_pkg.sv
// Shared types and constants for the MUL issue/completion controller.
package mul_sched_pkg;

  localparam int XLEN            = 32;
  localparam int PRF_LEN         = 6;
  localparam int ROB_LEN         = 5;
  // Depth of the external multiplier; must match mult's STAGE.
  localparam int MUL_PIPE_STAGES = 8;
  localparam int DEF_OUT_DEPTH   = 4;

  typedef enum logic [1:0] {
    ALU_MUL    = 2'd0,
    ALU_MULH   = 2'd1,
    ALU_MULHSU = 2'd2,
    ALU_MULHU  = 2'd3
  } mul_func_e;

  typedef struct packed {
    logic [XLEN-1:0]    opa;
    logic [XLEN-1:0]    opb;
    mul_func_e          mul_func;
    logic [PRF_LEN-1:0] dest_preg_idx;
    logic [ROB_LEN-1:0] rob_idx;
    logic [XLEN-1:0]    PC;
  } RS_MUL_PACKET;

  // Per-op bookkeeping that travels alongside the multiplier pipe.
  typedef struct packed {
    logic [PRF_LEN-1:0] prf;
    logic [ROB_LEN-1:0] rob;
    logic [XLEN-1:0]    PC;
    mul_func_e          func;
    logic               neg;
  } MUL_TAG;

  // One completed result waiting for the CDB.
  typedef struct packed {
    logic [XLEN-1:0]    value;
    logic [PRF_LEN-1:0] prf;
    logic [ROB_LEN-1:0] rob;
    logic [XLEN-1:0]    PC;
  } mul_result_t;

  // Returns {opa_is_signed, opb_is_signed} for a multiply function.
  function automatic logic [1:0] operand_signed(mul_func_e f);
    case (f)
      ALU_MUL, ALU_MULH: return 2'b11;
      ALU_MULHSU:        return 2'b10;
      default:           return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mul_result_fifo.sv
// Completed-result queue between the multiplier tag pipe and the CDB.
module mul_result_fifo
  import mul_sched_pkg::*;
#(
  parameter int DEPTH = DEF_OUT_DEPTH,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        push_i,
  input  mul_result_t push_data_i,
  input  logic        pop_i,
  output mul_result_t head_o,
  output logic        valid_o,
  output logic [PW:0] count_o
);

  mul_result_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && (count_q != '0) && !flush_i;

  // Next pointer/count values; flush wins over any push or pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state is updated with <= so every register samples pre-edge values.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clock) begin
    // NOTE: storage is not reset; entries are only read once count marks them valid.
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  // Credits guarantee a completion never meets a full queue.
  assert property (@(posedge clock) disable iff (reset)
    !(do_push && count_q == (PW+1)'(DEPTH)));

endmodule

// File: rtl/mul_sched.sv
// Issue/completion controller around the pipelined multiplier.
// Optional build macro MUL_SCHED_STATS_EN adds saturating activity counters.
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int MUL_STAGES = MUL_PIPE_STAGES,
  parameter int OUT_DEPTH  = DEF_OUT_DEPTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               squash,
  input  logic               rs_valid,
  input  RS_MUL_PACKET       rs_packet,
  output logic               rs_ready,
  output logic               mult_start,
  output logic [2*XLEN-1:0]  mult_mcand,
  output logic [2*XLEN-1:0]  mult_mplier,
  input  logic [2*XLEN-1:0]  mult_product,
  input  logic               mult_done,
  output logic               cdb_req,
  input  logic               cdb_grant,
  output logic [XLEN-1:0]    cdb_value,
  output logic [PRF_LEN-1:0] cdb_prf_idx,
  output logic [ROB_LEN-1:0] cdb_rob_idx,
  output logic [XLEN-1:0]    cdb_PC,
`ifdef MUL_SCHED_STATS_EN
  output logic [31:0]        stat_issued,
  output logic [31:0]        stat_stall,
  output logic [31:0]        stat_cdb_wait,
`endif
  output logic               seq_err
);

  localparam int CW = $clog2(OUT_DEPTH);
  localparam int MW = $clog2(MUL_STAGES + 1);

  logic                  fire, a_sgn, b_sgn;
  logic [XLEN-1:0]       mag_a, mag_b;
  MUL_TAG                tag_in;
  logic [MUL_STAGES-1:0] slot_vld_q, slot_vld_d;
  MUL_TAG                slot_tag_q [MUL_STAGES];
  logic [MW-1:0]         mask_q, mask_d;
  logic                  seq_err_q, seq_err_d;
  logic [2*XLEN-1:0]     res;
  mul_result_t           done_res, head;
  logic [CW:0]           fifo_count;
  logic                  done_vld;
  MUL_TAG                done_tag;

  // Credit check, sign handling and operand magnitudes for the issuing op.
  always_comb begin
    rs_ready = (32'(fifo_count) + 32'($countones(slot_vld_q))) < 32'(OUT_DEPTH);
    fire     = rs_valid && rs_ready;
    {a_sgn, b_sgn} = operand_signed(rs_packet.mul_func) &
                     {rs_packet.opa[XLEN-1], rs_packet.opb[XLEN-1]};
    mag_a    = a_sgn ? -rs_packet.opa : rs_packet.opa;
    mag_b    = b_sgn ? -rs_packet.opb : rs_packet.opb;
    tag_in   = '{prf: rs_packet.dest_preg_idx, rob: rs_packet.rob_idx,
                 PC: rs_packet.PC, func: rs_packet.mul_func, neg: a_sgn ^ b_sgn};
  end

  assign mult_start  = fire;
  assign mult_mcand  = {{XLEN{1'b0}}, mag_a};
  assign mult_mplier = {{XLEN{1'b0}}, mag_b};

  assign done_vld = slot_vld_q[MUL_STAGES-1];
  assign done_tag = slot_tag_q[MUL_STAGES-1];

  // Sign-correct the product and pick the half the function asks for.
  always_comb begin
    res      = done_tag.neg ? -mult_product : mult_product;
    done_res = '{value: (done_tag.func == ALU_MUL) ? res[XLEN-1:0] : res[2*XLEN-1:XLEN],
                 prf: done_tag.prf, rob: done_tag.rob, PC: done_tag.PC};
  end

  // Next-state for tag valids, post-squash mask and the sticky sequence error.
  always_comb begin
    slot_vld_d = squash ? '0 : {slot_vld_q[MUL_STAGES-2:0], fire};
    if (squash)            mask_d = MW'(MUL_STAGES);
    else if (mask_q != '0) mask_d = mask_q - 1'b1;
    else                   mask_d = mask_q;
    seq_err_d = seq_err_q || ((mask_q == '0) && (mult_done != done_vld));
  end

  // Control registers of the tag pipe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_vld_q <= '0;
      mask_q     <= '0;
      seq_err_q  <= 1'b0;
    end else begin
      slot_vld_q <= slot_vld_d;
      mask_q     <= mask_d;
      seq_err_q  <= seq_err_d;
    end
  end

  // Tag payload shifts every cycle in lockstep with the multiplier.
  always_ff @(posedge clock) begin
    slot_tag_q[0] <= tag_in;
    for (int i = 1; i < MUL_STAGES; i++) slot_tag_q[i] <= slot_tag_q[i-1];
  end

  assign seq_err = seq_err_q;

  mul_result_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .flush_i     (squash),
    .push_i      (done_vld),
    .push_data_i (done_res),
    .pop_i       (cdb_grant),
    .head_o      (head),
    .valid_o     (cdb_req),
    .count_o     (fifo_count)
  );

  assign cdb_value   = head.value;
  assign cdb_prf_idx = head.prf;
  assign cdb_rob_idx = head.rob;
  assign cdb_PC      = head.PC;

`ifdef MUL_SCHED_STATS_EN
  logic [31:0] stat_issued_q, stat_stall_q, stat_cdb_wait_q;

  // Saturating activity counters; only reset clears them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_issued_q   <= '0;
      stat_stall_q    <= '0;
      stat_cdb_wait_q <= '0;
    end else begin
      if (fire && stat_issued_q != '1) stat_issued_q <= stat_issued_q + 1'b1;
      if (rs_valid && !rs_ready && stat_stall_q != '1) stat_stall_q <= stat_stall_q + 1'b1;
      if (cdb_req && !cdb_grant && stat_cdb_wait_q != '1) stat_cdb_wait_q <= stat_cdb_wait_q + 1'b1;
    end
  end

  assign stat_issued   = stat_issued_q;
  assign stat_stall    = stat_stall_q;
  assign stat_cdb_wait = stat_cdb_wait_q;
`endif

endmodule

// File: tb/tb_mul_sched.sv
// Scoreboard bench for mul_sched with a stub multiplier and an arithmetic reference model.
module tb_mul_sched;
  import mul_sched_pkg::*;

  localparam int STAGES = MUL_PIPE_STAGES;
  localparam int DEPTH  = DEF_OUT_DEPTH;

  logic               clock = 1'b0;
  logic               reset, squash, rs_valid, rs_ready, mult_start, mult_done;
  logic               cdb_req, cdb_grant, seq_err;
  RS_MUL_PACKET       rs_packet;
  logic [2*XLEN-1:0]  mult_mcand, mult_mplier, mult_product;
  logic [XLEN-1:0]    cdb_value, cdb_PC;
  logic [PRF_LEN-1:0] cdb_prf_idx;
  logic [ROB_LEN-1:0] cdb_rob_idx;
`ifdef MUL_SCHED_STATS_EN
  logic [31:0]        stat_issued, stat_stall, stat_cdb_wait;
`endif

  mul_sched dut (
    .clock(clock), .reset(reset), .squash(squash), .rs_valid(rs_valid),
    .rs_packet(rs_packet), .rs_ready(rs_ready), .mult_start(mult_start),
    .mult_mcand(mult_mcand), .mult_mplier(mult_mplier),
    .mult_product(mult_product), .mult_done(mult_done),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_value(cdb_value),
    .cdb_prf_idx(cdb_prf_idx), .cdb_rob_idx(cdb_rob_idx), .cdb_PC(cdb_PC),
`ifdef MUL_SCHED_STATS_EN
    .stat_issued(stat_issued), .stat_stall(stat_stall), .stat_cdb_wait(stat_cdb_wait),
`endif
    .seq_err(seq_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Stub multiplier: STAGES-deep unsigned product pipe.
  logic [2*XLEN-1:0] mp_prod [STAGES];
  logic [STAGES-1:0] mp_vld;
  always @(posedge clock or posedge reset) begin
    if (reset) mp_vld <= '0;
    else begin
      mp_vld     <= {mp_vld[STAGES-2:0], mult_start};
      mp_prod[0] <= mult_mcand * mult_mplier;
      for (int i = 1; i < STAGES; i++) mp_prod[i] <= mp_prod[i-1];
    end
  end
  assign mult_product = mp_prod[STAGES-1];
  assign mult_done    = mp_vld[STAGES-1];

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference result from plain signed/unsigned arithmetic.
  function automatic logic [XLEN-1:0] ref_result(mul_func_e f, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    longint      sa, sb, ubl;
    logic [63:0] p;
    sa  = $signed(a);
    sb  = $signed(b);
    ubl = longint'({32'b0, b});
    case (f)
      ALU_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0];  end
      ALU_MULH:   begin p = sa * sb;                 return p[63:32]; end
      ALU_MULHSU: begin p = sa * ubl;                return p[63:32]; end
      default:    begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
    endcase
  endfunction

  function automatic logic [XLEN-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic RS_MUL_PACKET make_pkt(mul_func_e f, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    RS_MUL_PACKET p;
    p.opa = a; p.opb = b; p.mul_func = f;
    p.dest_preg_idx = PRF_LEN'($urandom);
    p.rob_idx       = ROB_LEN'($urandom);
    p.PC            = $urandom & 32'hFFFF_FFFC;
    return p;
  endfunction

  function automatic RS_MUL_PACKET rand_pkt();
    return make_pkt(mul_func_e'($urandom_range(0, 3)), pick_operand(), pick_operand());
  endfunction

  // Reference model: ops in the multiplier become visible at their due cycle.
  typedef struct {
    int                 due;
    logic [XLEN-1:0]    value;
    logic [PRF_LEN-1:0] prf;
    logic [ROB_LEN-1:0] rob;
    logic [XLEN-1:0]    pc;
  } exp_t;

  exp_t pipe_q[$];
  exp_t fifo_q[$];
  exp_t mon_e;
  logic mon_ready;

  // Monitor: compares DUT outputs against the model, then advances the model.
  always @(negedge clock) begin
    if (reset) begin
      pipe_q.delete();
      fifo_q.delete();
    end else begin
      while (pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
        mon_e = pipe_q.pop_front();
        fifo_q.push_back(mon_e);
      end
      mon_ready = (pipe_q.size() + fifo_q.size()) < DEPTH;
      check("rs_ready", rs_ready, mon_ready);
      check("cdb_req", cdb_req, fifo_q.size() > 0);
      check("seq_err", seq_err, 1'b0);
      if (cdb_req && fifo_q.size() > 0) begin
        check("cdb_value", cdb_value, fifo_q[0].value);
        check("cdb_prf_idx", cdb_prf_idx, fifo_q[0].prf);
        check("cdb_rob_idx", cdb_rob_idx, fifo_q[0].rob);
        check("cdb_PC", cdb_PC, fifo_q[0].pc);
      end
      if (squash) begin
        pipe_q.delete();
        fifo_q.delete();
      end else begin
        if (cdb_grant && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (rs_valid && mon_ready) begin
          mon_e.due   = cyc + STAGES + 1;
          mon_e.value = ref_result(rs_packet.mul_func, rs_packet.opa, rs_packet.opb);
          mon_e.prf   = rs_packet.dest_preg_idx;
          mon_e.rob   = rs_packet.rob_idx;
          mon_e.pc    = rs_packet.PC;
          pipe_q.push_back(mon_e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    rs_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Offer rs_valid with fresh random packets until n ops fire or the budget runs out.
  task automatic fire_n(input int n, input int budget, output int fired);
    fired = 0;
    for (int i = 0; i < budget && fired < n; i++) begin
      rs_valid  = 1'b1;
      rs_packet = rand_pkt();
      @(negedge clock);
      if (rs_ready) fired++;
      step();
    end
    rs_valid = 1'b0;
  endtask

  // Single op with grant held 1: checks issue-to-request latency and the known result.
  task automatic directed(input mul_func_e f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] exp_v);
    RS_MUL_PACKET p;
    int fire_cyc, req_cyc;
    bit seen;
    p = make_pkt(f, a, b);
    rs_packet = p;
    rs_valid  = 1'b1;
    seen = 0; fire_cyc = 0; req_cyc = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (rs_ready) begin seen = 1; fire_cyc = cyc; end
      step();
    end
    rs_valid = 1'b0;
    check("directed_fire", seen, 1'b1);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      if (cdb_req) begin
        seen = 1;
        req_cyc = cyc;
        check("directed_value", cdb_value, exp_v);
        check("directed_prf", cdb_prf_idx, p.dest_preg_idx);
        check("directed_rob", cdb_rob_idx, p.rob_idx);
        check("directed_pc", cdb_PC, p.PC);
      end
    end
    check("directed_req_seen", seen, 1'b1);
    check("directed_latency", 64'(req_cyc - fire_cyc), 64'(STAGES + 1));
    idle(3);
  endtask

  int fired;

  initial begin
    reset = 1'b1; squash = 1'b0; rs_valid = 1'b0; cdb_grant = 1'b0;
    rs_packet = '0;
    #1;
    check("reset_rs_ready", rs_ready, 1'b1);
    check("reset_cdb_req", cdb_req, 1'b0);
    check("reset_seq_err", seq_err, 1'b0);
    check("reset_cdb_value", cdb_value, '0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    idle(2);

    // Known-answer vectors.
    cdb_grant = 1'b1;
    directed(ALU_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    directed(ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    directed(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    directed(ALU_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);

    // Credit limit: no grants, constant offer.
    cdb_grant = 1'b0;
    fire_n(100, 20, fired);
    check("credit_fires", fired, DEPTH);
    @(negedge clock);
    check("credit_ready_low", rs_ready, 1'b0);
    step();
    cdb_grant = 1'b1;
    idle(10);

    // Back-to-back issue with the CDB always granting.
    fire_n(8, 100, fired);
    check("b2b_fires", fired, 8);
    idle(14);

    // Squash with queued and in-flight ops; the squash-cycle offer is dropped.
    cdb_grant = 1'b0;
    fire_n(2, 20, fired);
    idle(STAGES + 3);
    fire_n(1, 20, fired);
    idle(1);
    squash = 1'b1; rs_valid = 1'b1; rs_packet = rand_pkt();
    step();
    squash = 1'b0; rs_valid = 1'b0; cdb_grant = 1'b1;
    @(negedge clock);
    check("squash_req_low", cdb_req, 1'b0);
    check("squash_ready_high", rs_ready, 1'b1);
    idle(STAGES + 12);

    // Randomized traffic with occasional squashes.
    for (int i = 0; i < 400; i++) begin
      rs_valid  = $urandom_range(0, 9) < 7;
      rs_packet = rand_pkt();
      cdb_grant = $urandom_range(0, 9) < 6;
      squash    = $urandom_range(0, 99) < 3;
      step();
    end
    squash = 1'b0; cdb_grant = 1'b1;
    idle(STAGES + 8);

    // Asynchronous reset while results are draining.
    cdb_grant = 1'b0;
    fire_n(3, 20, fired);
    idle(STAGES + 3);
    cdb_grant = 1'b1;
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("async_reset_req", cdb_req, 1'b0);
    check("async_reset_ready", rs_ready, 1'b1);
    check("async_reset_value", cdb_value, '0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(STAGES + 4);
    directed(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
